pmux_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one parallel-mux ($pmux-style) datapath among N_REQ requesters.

---
 rtl/pmux_rr_scheduler.sv | 149 ++++++++++++++
 tb/tb_pmux_rr_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmux_rr_scheduler.sv
// Round-robin scheduler driving a shared one-hot pmux select into a registered output slot.
// Optional owner lock across transfers is enabled with `define PMUX_RR_LOCK_EN.
module pmux_rr_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
`ifdef PMUX_RR_LOCK_EN
    input  logic [N_REQ-1:0]       req_lock,
`endif
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [N_REQ-1:0]       grant_onehot
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]        r_ptr;
    logic                 r_valid;
    logic [WIDTH-1:0]     r_data;
    logic [N_REQ-1:0]     r_grant;

    logic                 w_slot_free;
    logic                 w_found;
    logic                 w_xfer;
    logic [PW-1:0]        w_winner;
    logic [N_REQ-1:0]     w_eligible;
    logic [N_REQ-1:0]     w_onehot;
    logic [WIDTH-1:0]     w_word;
    logic [2*N_REQ-1:0]   w_dbl;
    logic [N_REQ-1:0]     w_rot;
    int unsigned          w_off;
    int unsigned          w_sum;

`ifdef PMUX_RR_LOCK_EN
    typedef enum logic {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_t;

    lock_state_t          r_lock_st;
    lock_state_t          w_lock_nx;
    logic [PW-1:0]        r_owner;
    logic [PW-1:0]        w_owner_nx;
    logic [N_REQ-1:0]     w_owner_mask;

    always_comb begin
        w_owner_mask = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            w_owner_mask[j] = (j == 32'(r_owner));
        end
    end

    always_comb begin
        w_eligible = req_valid;
        if (r_lock_st == LK_HELD) begin
            w_eligible = req_valid & w_owner_mask;
        end
    end

    // While held only the owner can win, so any transfer's lock bit decides the next state.
    always_comb begin
        w_lock_nx  = r_lock_st;
        w_owner_nx = r_owner;
        if (w_xfer) begin
            if (req_lock[w_winner]) begin
                w_lock_nx  = LK_HELD;
                w_owner_nx = w_winner;
            end else begin
                w_lock_nx  = LK_OPEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_st <= LK_OPEN;
            r_owner   <= '0;
        end else begin
            r_lock_st <= w_lock_nx;
            r_owner   <= w_owner_nx;
        end
    end
`else
    always_comb begin
        w_eligible = req_valid;
    end
`endif

    // Rotate eligibility so bit 0 is the requester just after the pointer.
    always_comb begin
        w_dbl   = {w_eligible, w_eligible} >> (32'(r_ptr) + 32'd1);
        w_rot   = w_dbl[N_REQ-1:0];
        w_found = 1'b0;
        w_off   = 0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_off   = j;
            end
        end
        w_sum    = 32'(r_ptr) + 32'd1 + w_off;
        w_winner = PW'(w_sum % N_REQ);
    end

    always_comb begin
        w_onehot = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            w_onehot[j] = (j == 32'(w_winner));
        end
    end

    always_comb begin
        w_word = req_data[w_winner*WIDTH +: WIDTH];
    end

    assign w_slot_free = !r_valid || out_ready;
    assign w_xfer      = w_slot_free && w_found;
    assign req_ready   = w_xfer ? w_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_grant <= '0;
            r_ptr   <= PW'(N_REQ - 1);
        end else if (w_slot_free) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_data  <= w_word;
                r_grant <= w_onehot;
                r_ptr   <= w_winner;
            end else begin
                r_valid <= 1'b0;
                r_grant <= '0;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_data     = r_data;
    assign grant_onehot = r_grant;

endmodule

// File: tb/tb_pmux_rr_scheduler.sv
// Bench for pmux_rr_scheduler: directed literal scenarios plus randomized traffic against a behavioural model.
// Define PMUX_RR_LOCK_EN to also exercise the owner-lock scenario.
module tb_pmux_rr_scheduler;

    localparam int N = 4;
    localparam int W = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [N-1:0]   grant_onehot;

    int tests = 0;
    int fails = 0;

    pmux_rr_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
`ifdef PMUX_RR_LOCK_EN
        .req_lock     (req_lock),
`endif
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .grant_onehot (grant_onehot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: slot contents, owner index and pointer as plain integers.
    bit  m_known  = 0;
    bit  m_full   = 0;
    int  m_data   = 0;
    int  m_owner  = 0;
    int  m_ptr    = N - 1;
    bit  m_locked = 0;
    int  m_lowner = 0;

    function automatic int pick(input logic [N-1:0] elig, input int ptr);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (elig[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] elig;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_grant;
        bit           free;
        int           w;
        elig = req_valid;
`ifdef PMUX_RR_LOCK_EN
        if (m_locked) elig = req_valid & N'(1 << m_lowner);
`endif
        free = !m_full || out_ready;
        w    = pick(elig, m_ptr);
        if (m_known) begin
            exp_grant = m_full ? N'(1 << m_owner) : '0;
            chk("model_out_valid", 32'(out_valid), 32'(m_full));
            chk("model_out_data", 32'(out_data), 32'(m_data));
            chk("model_grant", 32'(grant_onehot), 32'(exp_grant));
            if (!rst) begin
                exp_ready = (free && w >= 0) ? N'(1 << w) : '0;
                chk("model_req_ready", 32'(req_ready), 32'(exp_ready));
            end
        end
        if (rst) begin
            m_known = 1; m_full = 0; m_data = 0; m_ptr = N - 1; m_locked = 0;
        end else if (m_known && free) begin
            if (w >= 0) begin
                m_full  = 1;
                m_data  = int'(req_data[w*W +: W]);
                m_owner = w;
                m_ptr   = w;
`ifdef PMUX_RR_LOCK_EN
                if (req_lock[w]) begin
                    m_locked = 1; m_lowner = w;
                end else begin
                    m_locked = 0;
                end
`endif
            end else begin
                m_full = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] g_seq [4];
        logic [W-1:0] d_seq [4];
        g_seq[0] = 4'b0001; g_seq[1] = 4'b0010; g_seq[2] = 4'b0100; g_seq[3] = 4'b1000;
        d_seq[0] = 2'b00;   d_seq[1] = 2'b01;   d_seq[2] = 2'b11;   d_seq[3] = 2'b10;

        rst = 1'b1; req_valid = '0; req_data = '0; req_lock = '0; out_ready = 1'b1;
        // Scenario 1: all valid, full-rate rotation from req0.
        req_valid = 4'b1111;
        req_data  = {2'b10, 2'b11, 2'b01, 2'b00};
        step(); step();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_grant", 32'(grant_onehot), 0);
        chk("reset_out_data", 32'(out_data), 0);
        rst = 1'b0;
        for (int k = 0; k < 11; k++) begin
            step();
            chk("rr_grant", 32'(grant_onehot), 32'(g_seq[k % 4]));
            chk("rr_data", 32'(out_data), 32'(d_seq[k % 4]));
            chk("rr_valid", 32'(out_valid), 1);
        end

        // Scenario 2: req2 word held under backpressure.
        out_ready = 1'b0;
        #1 chk("bp_ready_zero", 32'(req_ready), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'(2'b11));
            chk("bp_grant", 32'(grant_onehot), 32'(4'b0100));
            chk("bp_ready", 32'(req_ready), 0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'(4'b1000));
        step();
        chk("bp_next_grant", 32'(grant_onehot), 32'(4'b1000));

        // Scenario 3: sole requester 1 streams.
        req_valid = 4'b0010;
        #1 chk("solo_ready", 32'(req_ready), 32'(4'b0010));
        for (int k = 0; k < 4; k++) begin
            step();
            chk("solo_grant", 32'(grant_onehot), 32'(4'b0010));
            #1 chk("solo_ready", 32'(req_ready), 32'(4'b0010));
        end

        // Scenario 4: reset while the slot holds a req3 word.
        req_valid = 4'b1000;
        step();
        chk("pre_rst_grant", 32'(grant_onehot), 32'(4'b1000));
        out_ready = 1'b0; rst = 1'b1;
        step();
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_grant", 32'(grant_onehot), 0);
        rst = 1'b0; req_valid = 4'b1111; out_ready = 1'b1;
        step();
        chk("post_rst_grant", 32'(grant_onehot), 32'(4'b0001));

        // Scenario 5: idle gap keeps the pointer.
        req_valid = 4'b0100;
        step();
        chk("idle_pre_grant", 32'(grant_onehot), 32'(4'b0100));
        req_valid = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_grant", 32'(grant_onehot), 0);
            chk("idle_data_hold", 32'(out_data), 32'(2'b11));
        end
        req_valid = 4'b0001;
        step();
        chk("idle_req0_grant", 32'(grant_onehot), 32'(4'b0001));
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        step(); step(); step();
        req_valid = 4'b1011;
        step();
        chk("idle_ptr_held", 32'(grant_onehot), 32'(4'b1000));

`ifdef PMUX_RR_LOCK_EN
        // Scenario 6: req2 locks for three transfers, the fourth releases.
        req_valid = 4'b0010; req_lock = '0;
        step();
        chk("lock_setup", 32'(grant_onehot), 32'(4'b0010));
        req_valid = 4'b1111; req_lock = 4'b0100;
        step();
        chk("lock_t1", 32'(grant_onehot), 32'(4'b0100));
        #1 chk("lock_t1_ready", 32'(req_ready), 32'(4'b0100));
        step();
        chk("lock_t2", 32'(grant_onehot), 32'(4'b0100));
        req_valid = 4'b1011;
        #1 chk("lock_idle_ready", 32'(req_ready), 0);
        step();
        chk("lock_idle_valid", 32'(out_valid), 0);
        req_valid = 4'b1111;
        step();
        chk("lock_t3", 32'(grant_onehot), 32'(4'b0100));
        req_lock = '0;
        step();
        chk("lock_t4", 32'(grant_onehot), 32'(4'b0100));
        step();
        chk("lock_after", 32'(grant_onehot), 32'(4'b1000));
`endif

        // Randomized traffic; the negedge model checks every cycle.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #2;
            req_valid = N'($urandom_range(0, 15));
            req_data  = (N*W)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 59) == 0);
            req_lock  = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #6;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
